// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ  = 2;
  localparam int REQ_ID_W = 1;

  // Response FSM: S_RESP means a response is due this cycle
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } arb_state_t;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // The requester that is not 'id'
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of one port of a synchronous read-first RAM.
// One access per cycle, response one cycle after acceptance carrying ram_q.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for alternating conflict
// priority; otherwise requester 0 always wins a conflict.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_q
);

  logic       w_conflict;
  logic       w_prio1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_accept;
  req_id_t    w_acc_id;
  arb_state_t r_state;
  arb_state_t w_state_nxt;
  req_id_t    r_owner;
  req_id_t    w_owner_nxt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t r_prio;

  // Conflict-winner pointer; moves to the loser only when a conflict is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_prio <= REQ0;
    else if (w_conflict) r_prio <= other_req(r_prio);
  end

  assign w_prio1 = (r_prio == REQ1);
`else
  assign w_prio1 = 1'b0;
`endif

  // Grant: a lone requester always wins; a conflict goes to the priority holder.
  // Gated by rst_n so nothing is granted while reset is asserted.
  always_comb begin
    w_conflict = rst_n & req0_valid & req1_valid;
    w_gnt0     = rst_n & req0_valid & (~req1_valid | ~w_prio1);
    w_gnt1     = rst_n & req1_valid & (~req0_valid |  w_prio1);
    w_accept   = w_gnt0 | w_gnt1;
    w_acc_id   = w_gnt1 ? REQ1 : REQ0;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // RAM port follows the granted requester in the same cycle
  always_comb begin
    ram_addr = '0;
    ram_d    = '0;
    ram_we   = 1'b0;
    if (w_gnt0) begin
      ram_addr = req0_addr;
      ram_d    = req0_wdata;
      ram_we   = req0_we;
    end else if (w_gnt1) begin
      ram_addr = req1_addr;
      ram_d    = req1_wdata;
      ram_we   = req1_we;
    end
  end

  // FSM state register: remembers whether a response is due and for whom.
  // Async reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= REQ0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // FSM next state: every accept schedules a response for the next cycle
  always_comb begin
    w_state_nxt = S_IDLE;
    w_owner_nxt = r_owner;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_RESP;
        w_owner_nxt = w_acc_id;
      end
      S_RESP: if (w_accept) begin
        w_state_nxt = S_RESP;
        w_owner_nxt = w_acc_id;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: one-cycle strobe to the owner, rdata zero when not strobed
  always_comb begin
    rsp0_valid = rst_n & (r_state == S_RESP) & (r_owner == REQ0);
    rsp1_valid = rst_n & (r_state == S_RESP) & (r_owner == REQ1);
    rsp0_rdata = rsp0_valid ? ram_q : '0;
    rsp1_rdata = rsp1_valid ? ram_q : '0;
  end

endmodule
